// File: rtl/mux_arb_nbit.sv
// N-channel, W-bit registered selector with valid/ready handshake.
// Arbitration is fixed priority, round-robin or static select, chosen by MODE.
module mux_arb_nbit #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int MODE     = 1,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SW-1:0]             sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SW-1:0]             out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0] grant;
    logic [SW-1:0]       gidx;
    logic [SW-1:0]       cand;
    logic [SW-1:0]       ptr;
    logic [SW-1:0]       ptr_next;
    logic [WIDTH-1:0]    grant_data;
    logic                found;
    logic                can_load;
    logic                in_xfer;

    // One search loop serves all modes: the start offset is ptr only in
    // round-robin, and static select just masks every candidate but sel.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (MODE == 1)
                cand = SW'((32'(ptr) + k) % CHANNELS);
            else
                cand = SW'(k);
            if (!found && in_valid[cand] && (MODE != 2 || sel == cand)) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i])
                grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign ptr_next = (gidx == SW'(CHANNELS - 1)) ? '0 : gidx + 1'b1;
    assign can_load = !out_valid || out_ready;
    assign in_ready = rst ? '0 : (grant & {CHANNELS{can_load}});
    assign in_xfer  = |in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (in_xfer) begin
            out_data  <= grant_data;
            out_sel   <= gidx;
            out_valid <= 1'b1;
            if (MODE == 1)
                ptr <= ptr_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nbit.sv
// Scoreboard bench for mux_arb_nbit: one instance per arbitration mode,
// expected {out_sel,out_data} words queued at drive time, popped on output transfer.
module tb_mux_arb_nbit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  rv, fv, sv;
    logic [15:0] rd, fd, sd;
    logic        rr, fr, sr;
    logic [1:0]  sel;

    logic [3:0] r_ir, f_ir, s_ir;
    logic [3:0] r_od, f_od, s_od;
    logic [1:0] r_os, f_os, s_os;
    logic       r_ov, f_ov, s_ov;

    logic [7:0] rq[$];
    logic [7:0] fq[$];
    logic [7:0] sq[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] wrap_exp [5] = '{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h0A};
    logic [7:0] sp_exp   [2] = '{8'h3D, 8'h0A};
    logic [3:0] sp_rdy   [2] = '{4'b1000, 4'b0001};

    mux_arb_nbit #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(rd), .in_valid(rv), .in_ready(r_ir),
        .sel(sel), .out_data(r_od), .out_sel(r_os), .out_valid(r_ov), .out_ready(rr)
    );

    mux_arb_nbit #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_fp (
        .clk(clk), .rst(rst), .in_data(fd), .in_valid(fv), .in_ready(f_ir),
        .sel(sel), .out_data(f_od), .out_sel(f_os), .out_valid(f_ov), .out_ready(fr)
    );

    mux_arb_nbit #(.WIDTH(4), .CHANNELS(4), .MODE(2)) u_st (
        .clk(clk), .rst(rst), .in_data(sd), .in_valid(sv), .in_ready(s_ir),
        .sel(sel), .out_data(s_od), .out_sel(s_os), .out_valid(s_ov), .out_ready(sr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // 8'hFF can never be produced (6 significant bits), so an unexpected word fails.
    always @(negedge clk) begin
        if (!rst) begin
            if (r_ov && rr) check("rr_out", {r_os, r_od}, rq.size() > 0 ? rq.pop_front() : 8'hFF);
            if (f_ov && fr) check("fp_out", {f_os, f_od}, fq.size() > 0 ? fq.pop_front() : 8'hFF);
            if (s_ov && sr) check("st_out", {s_os, s_od}, sq.size() > 0 ? sq.pop_front() : 8'hFF);
        end
    end

    initial begin
        rst = 1'b1;
        rv = 4'b1111; fv = '0; sv = '0;
        rr = 1'b1; fr = 1'b1; sr = 1'b1;
        sel = 2'd2;
        rd = {4'hD, 4'hC, 4'hB, 4'hA};
        fd = {4'h4, 4'h3, 4'h2, 4'h1};
        sd = {4'h9, 4'h7, 4'h6, 4'h5};

        @(negedge clk);
        check("rst_valid", r_ov, 0);
        check("rst_data",  r_od, 0);
        check("rst_sel",   r_os, 0);
        check("rst_ready", r_ir, 0);
        next_cycle();
        rst = 1'b0;

        // Round-robin wrap with every channel valid
        for (int k = 0; k < 5; k++) begin
            rq.push_back(wrap_exp[k]);
            @(negedge clk);
            check("rr_wrap_rdy", r_ir, 32'(1) << (k % 4));
            next_cycle();
        end
        rv = '0;
        repeat (2) next_cycle();

        // Sparse round-robin from ptr=1
        rv = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            rq.push_back(sp_exp[k]);
            @(negedge clk);
            check("rr_sparse_rdy", r_ir, sp_rdy[k]);
            next_cycle();
        end
        rv = '0;
        repeat (2) next_cycle();

        // Backpressure: held word and frozen pointer
        rr = 1'b0;
        rv = 4'b1111;
        rq.push_back(8'h1B);
        @(negedge clk);
        check("bp_first_rdy", r_ir, 4'b0010);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_rdy",   r_ir, 0);
            check("bp_hold_data",  r_od, 4'hB);
            check("bp_hold_valid", r_ov, 1);
            next_cycle();
        end
        rr = 1'b1;
        rq.push_back(8'h2C);
        @(negedge clk);
        check("bp_release_rdy", r_ir, 4'b0100);
        next_cycle();
        rv = '0;
        @(negedge clk);
        check("bp_reload_data", r_od, 4'hC);
        next_cycle();
        repeat (2) next_cycle();

        // Asynchronous reset with a held word
        rr = 1'b0;
        rv = 4'b1111;
        next_cycle();
        check("ar_held_valid", r_ov, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", r_ov, 0);
        check("ar_data",  r_od, 0);
        check("ar_sel",   r_os, 0);
        check("ar_ready", r_ir, 0);
        next_cycle();
        rst = 1'b0;
        rr = 1'b1;
        rq.push_back(8'h0A);
        @(negedge clk);
        check("ar_first_rdy", r_ir, 4'b0001);
        next_cycle();
        rv = '0;
        repeat (2) next_cycle();

        // Fixed priority: channel 1 always beats channel 2
        fv = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            fq.push_back(8'h12);
            @(negedge clk);
            check("fp_rdy", f_ir, 4'b0010);
            next_cycle();
        end
        fv = '0;
        repeat (2) next_cycle();

        // Static select on channel 2
        sv = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("st_nogrant_rdy",   s_ir, 0);
            check("st_nogrant_valid", s_ov, 0);
            next_cycle();
        end
        sv = 4'b0111;
        sq.push_back(8'h27);
        @(negedge clk);
        check("st_grant_rdy", s_ir, 4'b0100);
        next_cycle();
        sv = '0;
        @(negedge clk);
        check("st_out_data", s_od, 4'h7);
        check("st_out_sel",  s_os, 2);
        next_cycle();
        repeat (2) next_cycle();

        check("rr_queue_empty", rq.size(), 0);
        check("fp_queue_empty", fq.size(), 0);
        check("st_queue_empty", sq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
